// File: rtl/hazard_pkg.sv
// Shared types and helpers for the multicycle hazard detection unit.
// Holds the FSM state encoding, the zero-register index and cnt sizing.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    BR_WAIT   = 2'd2
  } hdu_state_t;

  localparam int unsigned REG_ZERO = 0;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hdu_stall_counter.sv
// Loadable down-counter shared by both wait states of the hazard unit.
// Ports: clk, rst (async, active-low), clr, load, load_val, en -> done.
module hdu_stall_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Set in the last cycle of a wait state.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/hdu_multicycle.sv
// Multicycle load-use / branch hazard detection between IF/ID and ID/EX.
// Ports: IF/ID sources, ID/EX dest, branch/flush controls -> stall outputs.
// Optional HDU_PERF_CNT_EN adds load/branch stall cycle counters.
module hdu_multicycle
  import hazard_pkg::*;
#(
  parameter int REGFILE_LEN    = 6,
  parameter int LOAD_LAT       = 2,
  parameter int BRANCH_PENALTY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REGFILE_LEN-1:0] rs1_IF_ID,
  input  logic [REGFILE_LEN-1:0] rs2_IF_ID,
  input  logic                   rs1_used_IF_ID,
  input  logic                   rs2_used_IF_ID,
  input  logic [REGFILE_LEN-1:0] rd_ID_EX,
  input  logic                   mem_read_ID_EX,
  input  logic                   reg_write_ID_EX,
  input  logic                   branch_src_IF_ID,
  input  logic                   branch_resolved,
  input  logic                   flush,
  output logic                   load_stall,
  output logic                   branch_stall,
  output logic                   stall,
  output logic                   bubble_ID_EX,
  output logic                   busy
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [31:0]            load_stall_cycles,
  output logic [31:0]            branch_stall_cycles
`endif
);

  localparam int CW = cnt_w(LOAD_LAT, BRANCH_PENALTY);
  localparam logic [REGFILE_LEN-1:0] ZERO =
    REGFILE_LEN'(REG_ZERO);

  hdu_state_t    state, state_nx;
  logic          ld, en, clr, done;
  logic [CW-1:0] ld_val;
  logic          ls, bs;
  logic          load_hit, br_hit;

  assign load_hit = mem_read_ID_EX & reg_write_ID_EX &
                    (rd_ID_EX != ZERO) &
                    ((rs1_used_IF_ID & (rd_ID_EX == rs1_IF_ID)) |
                     (rs2_used_IF_ID & (rd_ID_EX == rs2_IF_ID)));
  assign br_hit   = branch_src_IF_ID;

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_val   = '0;
    en       = 1'b0;
    clr      = 1'b0;
    ls       = 1'b0;
    bs       = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      clr      = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_hit) begin
            ls = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nx = LOAD_WAIT;
              ld       = 1'b1;
              ld_val   = CW'(LOAD_LAT - 1);
            end
          end else if (br_hit) begin
            bs = 1'b1;
            if (BRANCH_PENALTY > 1 && !branch_resolved) begin
              state_nx = BR_WAIT;
              ld       = 1'b1;
              ld_val   = CW'(BRANCH_PENALTY - 1);
            end
          end
        end
        LOAD_WAIT: begin
          ls = 1'b1;
          en = 1'b1;
          if (done) state_nx = IDLE;
        end
        BR_WAIT: begin
          // Resolution releases the stall in the same cycle.
          if (branch_resolved) begin
            state_nx = IDLE;
            clr      = 1'b1;
          end else begin
            bs = 1'b1;
            en = 1'b1;
            if (done) state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          clr      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  hdu_stall_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (ld),
    .load_val (ld_val),
    .en       (en),
    .done     (done)
  );

  assign load_stall   = rst & ls;
  assign branch_stall = rst & bs;
  assign stall        = load_stall | branch_stall;
  assign bubble_ID_EX = stall;
  assign busy         = rst & (state != IDLE);

`ifdef HDU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_stall_cycles   <= '0;
      branch_stall_cycles <= '0;
    end else begin
      if (load_stall && load_stall_cycles != '1)
        load_stall_cycles <= load_stall_cycles + 32'd1;
      if (branch_stall && branch_stall_cycles != '1)
        branch_stall_cycles <= branch_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hdu_multicycle.md
Name: hdu_multicycle

Overview:
- Parametrised successor to the single-cycle hazard detection unit.
- Sits between the IF/ID and ID/EX pipeline registers.
- Detects load-use and branch hazards, then holds the stall for a configurable number of cycles, so memories with more than one cycle of latency and deeper branch resolution are supported.
- Adds x0 exclusion, source-use qualification, early release on branch resolution, and a pipeline-flush abort.

Parameters:
- REGFILE_LEN, 6, width of a register index.
- LOAD_LAT, 2, total stall cycles per load-use hazard (>=1).
- BRANCH_PENALTY, 3, maximum stall cycles per branch (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- rs1_IF_ID  input  REGFILE_LEN  source register 1 of the decoding instruction.
- rs2_IF_ID  input  REGFILE_LEN  source register 2 of the decoding instruction.
- rs1_used_IF_ID  input  1  instruction reads rs1.
- rs2_used_IF_ID  input  1  instruction reads rs2.
- rd_ID_EX  input  REGFILE_LEN  destination register of the instruction in EX.
- mem_read_ID_EX  input  1  instruction in EX is a load.
- reg_write_ID_EX  input  1  instruction in EX writes rd.
- branch_src_IF_ID  input  1  decoding instruction is a branch or jump.
- branch_resolved  input  1  EX has resolved the outstanding branch.
- flush  input  1  pipeline flush; aborts any stall.
- load_stall  output  1  load-use stall active.
- branch_stall  output  1  branch stall active.
- stall  output  1  load_stall OR branch_stall; holds PC and IF/ID.
- bubble_ID_EX  output  1  insert a NOP into ID/EX this cycle.
- busy  output  1  FSM is not IDLE.

Behaviour:
- Reset: rst low asynchronously forces state IDLE and cnt 0; all outputs are 0 while rst is low.
- Hazard definitions:
  - load_hit = mem_read_ID_EX & reg_write_ID_EX & (rd_ID_EX != 0) & ((rs1_used_IF_ID & rd_ID_EX==rs1_IF_ID) | (rs2_used_IF_ID & rd_ID_EX==rs2_IF_ID)).
  - br_hit = branch_src_IF_ID.
- States: IDLE, LOAD_WAIT, BR_WAIT. cnt width is $clog2(max(LOAD_LAT, BRANCH_PENALTY)+1).
- IDLE:
  - load_hit: load_stall=1 combinationally in the same cycle (0-cycle latency). If LOAD_LAT>1, go to LOAD_WAIT with cnt=LOAD_LAT-1; otherwise remain IDLE.
  - br_hit and not load_hit: branch_stall=1 in the same cycle. If BRANCH_PENALTY>1 and !branch_resolved, go to BR_WAIT with cnt=BRANCH_PENALTY-1; otherwise remain IDLE.
  - load_hit and br_hit together: the load has priority and branch_stall stays 0. The branch is re-detected when the FSM returns to IDLE, because IF/ID is held.
- LOAD_WAIT: load_stall=1; cnt decrements each cycle. When cnt==1 at the clock edge, go to IDLE. New hazards are ignored in this state.
- BR_WAIT:
  - branch_stall=1; cnt decrements each cycle.
  - branch_resolved=1: branch_stall=0 in that same cycle and the FSM goes to IDLE.
  - Otherwise the FSM goes to IDLE when cnt==1.
- stall = load_stall | branch_stall.
- bubble_ID_EX = stall.
- busy = (state != IDLE).
- flush=1 in any state:
  - All stall outputs are 0 that cycle; this overrides detection.
  - Next state is IDLE and cnt is 0.
- Total stall length:
  - Load-use: exactly LOAD_LAT consecutive cycles.
  - Branch: min(BRANCH_PENALTY, cycles until branch_resolved) cycles. A resolution arriving in the detection cycle gives 1 cycle.
- Reset asserted mid-stall aborts immediately; the first cycle after release is IDLE.

Optional Feature:
- Macro: HDU_PERF_CNT_EN.
- Enabled:
  - Adds 32-bit output ports load_stall_cycles and branch_stall_cycles.
  - Each counts the cycles in which its stall output is 1.
  - Both saturate at 0xFFFFFFFF and reset to 0 on rst.
- Disabled: the ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - State enum: IDLE=2'd0, LOAD_WAIT=2'd1, BR_WAIT=2'd2.
  - Zero-register constant REG_ZERO.
  - A cnt-width helper function.
- One sub-module, hdu_stall_counter: a loadable down-counter with load value, enable, clear and a done flag. It is instantiated once and shared by both wait states.

Test Plan:
- Load-use hazard, LOAD_LAT=2: rd_ID_EX=5, mem_read_ID_EX=1, reg_write_ID_EX=1, rs1_IF_ID=5, rs1_used_IF_ID=1 → load_stall=1 for exactly 2 cycles and busy=1 in the second cycle only.
- Zero register and unused source: rd_ID_EX=0 with a matching rs1 gives load_stall=0. rs2_IF_ID=7 matching rd_ID_EX=7 with rs2_used_IF_ID=0 gives load_stall=0.
- Branch, BRANCH_PENALTY=3: branch_src_IF_ID=1 with no resolution → branch_stall=1 for 3 cycles. Repeat with branch_resolved=1 in the 2nd cycle → branch_stall is 1 for 1 cycle, then 0.
- Simultaneous load_hit and br_hit: load_stall=1 and branch_stall=0 for LOAD_LAT cycles, then branch_stall=1.
- flush=1 in the second cycle of BR_WAIT → stall=0 in that cycle and busy=0 the next. Separately, rst low mid-LOAD_WAIT → all outputs 0 immediately.
- With HDU_PERF_CNT_EN: after one load hazard (LOAD_LAT=2) and one unresolved branch (BRANCH_PENALTY=3), load_stall_cycles=2 and branch_stall_cycles=3.
